conv_encoder_punct: RTL and testbench
=====================================

// Module: conv_encoder_punct
// PURPOSE
//  Parametrised rate-1/2 convolutional encoder with selectable puncturing (1/2, 2/3, 3/4)
//  and automatic zero-tail termination. Per-bit valid/ready handshake on both sides.
//  Punctured bits are flagged by a mask output; no Z values are driven.
//  Sits between the bit source and the modulator/interleaver in the TX chain.
// PARAMETERS
//  K   3        constraint length, 2..9; encoder memory is K-1 bits
//  G0  3'b111   generator for out_par[1], K bits (octal 7)
//  G1  3'b101   generator for out_par[0], K bits (octal 5)
// PORTS
//  CLK       in   1  clock; all logic on posedge
//  RST       in   1  synchronous, active-high reset
//  mode      in   2  0=1/2, 1=2/3, 2=3/4, 3=treated as 1/2; latched at frame start
//  in_bit    in   1  data bit
//  in_valid  in   1  in_bit valid
//  in_last   in   1  qualifies the final data bit of the frame
//  in_ready  out  1  bit accepted when in_valid & in_ready
//  out_par   out  2  {p1,p0} coded bits
//  out_mask  out  2  1 = bit transmitted, 0 = punctured (out_par bit is 0)
//  out_valid out  1  out_par/out_mask/out_last valid
//  out_last  out  1  final symbol of the frame (last tail symbol)
//  out_ready in   1  symbol consumed when out_valid & out_ready
// BEHAVIOUR
//  - Window w[K-1:0]: w[K-1]=current input, w[K-2:0]=shift reg s (s[K-2] newest).
//    p1 = ^(w & G0), p0 = ^(w & G1). Next s = {in, s[K-2:1]}.
//  - Reset (sync, RST=1): s=0, pcnt=0, fsm=DATA, frame_start=1, mode_q=0, out_valid=0,
//    out_par=0, out_mask=0, out_last=0. Reset mid-frame discards everything in flight.
//  - Output is a single register stage. adv = !out_valid | out_ready.
//    in_ready = (fsm==DATA) & adv. Latency: accepted bit -> symbol on next cycle.
//    While out_valid & !out_ready, all outputs hold stable.
//    If adv and no new symbol is produced, out_valid drops to 0.
//  - FSM DATA: on accept, produce a symbol and shift s.
//    If frame_start: mode_q <= mode, frame_start <= 0, and the symbol uses the new mode.
//    If in_last: go to TAIL with tcnt=K-2.
//  - FSM TAIL: in_ready=0. On each adv cycle, encode in=0 and decrement tcnt.
//    The symbol with tcnt==0 carries out_last=1. Then s=0, pcnt=0, frame_start=1, fsm=DATA.
//  - Puncturing: pcnt counts symbols within the frame, including tail symbols.
//    pcnt wraps at period P: P=1 for 1/2, P=2 for 2/3, P=3 for 3/4.
//    - 1/2: mask 11 always.
//    - 2/3: pcnt 0 -> 11, pcnt 1 -> 10.
//    - 3/4: pcnt 0 -> 11, pcnt 1 -> 10, pcnt 2 -> 01.
//    Masked-off out_par bits are forced to 0.
//  - mode changes mid-frame are ignored; mode_q applies to the whole frame, tail included.
//  - A single-bit frame (in_last on the first bit) is legal and yields 1+(K-1) symbols.
//  - in_valid with in_ready=0 is held by the source; in_bit/in_last are ignored until accepted.
// TESTING
//  1. K=3, mode 0, bits 1,0,1,1,0 (last on 5th), out_ready=1 ->
//     out_par 11,10,00,01,01,11,00; mask 11 each; out_last on 7th only.
//  2. K=3, mode 2, bits 1,1,1 (last on 3rd) ->
//     (par,mask) = (11,11),(00,10),(00,01),(01,11),(10,10); out_last on 5th.
//  3. Test 1 with out_ready low for 4 cycles after symbol 2 ->
//     outputs stable and in_ready=0 during the stall; same 7 symbols, none lost or duplicated.
//  4. RST pulsed during TAIL of test 1 ->
//     next cycle out_valid=0, in_ready=1; rerunning test 1 reproduces its output exactly.
//  5. mode=1 at the first bit, then mode=2 for the rest of 1,0,1,1,0 ->
//     masks 11,10,11,10,... using 2/3 throughout. Next frame with mode=3 -> all masks 11.
//  6. K=7, G0=7'o171, G1=7'o133, mode 0, single bit 1 with in_last ->
//     out_par 11,10,11,11,00,01,11; out_last on 7th.

Source files
------------

// File: rtl/conv_encoder_punct.sv
// Rate-1/2 convolutional encoder with 1/2, 2/3 and 3/4 puncturing and zero-tail termination.
// Each bit has a valid/ready handshake. The output is a single register stage that stalls on out_ready.
module conv_encoder_punct #(
    parameter int           K  = 3,
    parameter logic [K-1:0] G0 = 3'b111,
    parameter logic [K-1:0] G1 = 3'b101
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] mode,
    input  logic       in_bit,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [1:0] out_par,
    output logic [1:0] out_mask,
    output logic       out_valid,
    output logic       out_last,
    input  logic       out_ready
);

    localparam int TW = 4;

    typedef enum logic {DATA, TAIL} state_t;

    state_t          state_q, state_d;
    logic [K-2:0]    s_q, s_d;
    logic [1:0]      pcnt_q, pcnt_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic            fs_q, fs_d;
    logic [1:0]      mode_q, mode_d;
    logic [1:0]      par_d, mask_d;
    logic            valid_d, last_d;

    logic            adv;
    logic            produce;
    logic            cur_in;
    logic            frame_end;
    logic [1:0]      eff_mode;
    logic [1:0]      pmask;
    logic [1:0]      plast;
    logic [K-1:0]    w;

    assign adv      = !out_valid || out_ready;
    assign in_ready = (state_q == DATA) && adv;

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        pcnt_d    = pcnt_q;
        tcnt_d    = tcnt_q;
        fs_d      = fs_q;
        mode_d    = mode_q;
        par_d     = out_par;
        mask_d    = out_mask;
        last_d    = out_last;
        valid_d   = out_valid && !adv;
        produce   = 1'b0;
        cur_in    = 1'b0;
        frame_end = 1'b0;
        eff_mode  = mode_q;

        case (state_q)
            DATA: begin
                if (in_valid && adv) begin
                    produce = 1'b1;
                    cur_in  = in_bit;
                    // The first symbol of a frame is punctured with the mode sampled on the same cycle.
                    if (fs_q) begin
                        eff_mode = mode;
                        mode_d   = mode;
                        fs_d     = 1'b0;
                    end
                    if (in_last) begin
                        state_d = TAIL;
                        tcnt_d  = TW'(K - 2);
                    end
                end
            end
            TAIL: begin
                if (adv) begin
                    produce = 1'b1;
                    if (tcnt_q == '0) begin
                        frame_end = 1'b1;
                        state_d   = DATA;
                        fs_d      = 1'b1;
                    end else begin
                        tcnt_d = tcnt_q - 1'b1;
                    end
                end
            end
            default: state_d = DATA;
        endcase

        case (eff_mode)
            2'd1: begin
                plast = 2'd1;
                pmask = (pcnt_q == 2'd0) ? 2'b11 : 2'b10;
            end
            2'd2: begin
                plast = 2'd2;
                pmask = (pcnt_q == 2'd0) ? 2'b11 : (pcnt_q == 2'd1) ? 2'b10 : 2'b01;
            end
            default: begin
                plast = 2'd0;
                pmask = 2'b11;
            end
        endcase

        w = {cur_in, s_q};
        if (produce) begin
            par_d   = {^(w & G0), ^(w & G1)} & pmask;
            mask_d  = pmask;
            last_d  = frame_end;
            valid_d = 1'b1;
            s_d     = w[K-1:1];
            pcnt_d  = (pcnt_q == plast) ? 2'd0 : pcnt_q + 2'd1;
            if (frame_end) begin
                s_d    = '0;
                pcnt_d = 2'd0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= DATA;
            s_q       <= '0;
            pcnt_q    <= 2'd0;
            tcnt_q    <= '0;
            fs_q      <= 1'b1;
            mode_q    <= 2'd0;
            out_par   <= 2'b00;
            out_mask  <= 2'b00;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_q       <= s_d;
            pcnt_q    <= pcnt_d;
            tcnt_q    <= tcnt_d;
            fs_q      <= fs_d;
            mode_q    <= mode_d;
            out_par   <= par_d;
            out_mask  <= mask_d;
            out_valid <= valid_d;
            out_last  <= last_d;
        end
    end

endmodule

// File: tb/tb_conv_encoder_punct.sv
// Bench for conv_encoder_punct: directed frames and random frames with a convolution-sum reference.
// Two instances are used: K=3 (7,5) and K=7 (171,133).
module tb_conv_encoder_punct;

    typedef bit         bitq_t[$];
    typedef logic [3:0] symq_t[$];

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [1:0] mode = 2'd0;
    logic       in_bit = 1'b0;
    logic       iv = 1'b0;
    logic       in_last = 1'b0;
    logic       rdy = 1'b1;
    logic       sel7 = 1'b0;

    logic       ir3, ir7, ov3, ov7, ol3, ol7;
    logic [1:0] par3, par7, msk3, msk7;

    wire        iv3   = iv & ~sel7;
    wire        iv7   = iv & sel7;
    wire        m_ir  = sel7 ? ir7 : ir3;
    wire        m_ov  = sel7 ? ov7 : ov3;
    wire        m_ol  = sel7 ? ol7 : ol3;
    wire  [1:0] m_par = sel7 ? par7 : par3;
    wire  [1:0] m_msk = sel7 ? msk7 : msk3;

    int    n_cmp = 0;
    int    n_bad = 0;
    bitq_t bq;
    symq_t xq;

    always #5 CLK = ~CLK;

    conv_encoder_punct #(.K(3), .G0(3'b111), .G1(3'b101)) dut (
        .CLK(CLK), .RST(RST), .mode(mode), .in_bit(in_bit), .in_valid(iv3), .in_last(in_last),
        .in_ready(ir3), .out_par(par3), .out_mask(msk3), .out_valid(ov3), .out_last(ol3),
        .out_ready(rdy)
    );

    conv_encoder_punct #(.K(7), .G0(7'o171), .G1(7'o133)) dut7 (
        .CLK(CLK), .RST(RST), .mode(mode), .in_bit(in_bit), .in_valid(iv7), .in_last(in_last),
        .in_ready(ir7), .out_par(par7), .out_mask(msk7), .out_valid(ov7), .out_last(ol7),
        .out_ready(rdy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Load bits MSB-first: the first bit sent is v[n-1].
    task automatic load_bits(input logic [31:0] v, input int n);
        bq.delete();
        for (int i = 0; i < n; i++) bq.push_back(bit'((v >> (n - 1 - i)) & 32'd1));
    endtask

    // Load expected {par,mask} nibbles, with the first symbol in the top nibble.
    task automatic load_exp(input logic [31:0] v, input int n);
        xq.delete();
        for (int i = 0; i < n; i++) xq.push_back(4'((v >> (4 * (n - 1 - i))) & 32'hF));
    endtask

    task automatic run_frame(input bit use7, input logic [1:0] mf, input logic [1:0] mr,
                             input int stall_at, input int rst_at, input bit rnd, input string tag);
        int         n_bits, kx, g0, g1, per, nsym;
        int         bi, ri, cyc, stall;
        bit         acc, stalled;
        logic [5:0] snap;
        symq_t      ex;

        sel7   = use7;
        n_bits = bq.size();
        kx     = use7 ? 7 : 3;
        g0     = use7 ? 'o171 : 'o7;
        g1     = use7 ? 'o133 : 'o5;
        per    = (mf == 2'd1) ? 2 : (mf == 2'd2) ? 3 : 1;

        // Reference model: the coded bit at time n is the GF(2) convolution of the zero-padded data with the generator taps.
        if (xq.size() > 0) begin
            ex = xq;
        end else begin
            for (int n = 0; n < n_bits + kx - 1; n++) begin
                int p1, p0, u, ph, mk;
                p1 = 0;
                p0 = 0;
                for (int j = 0; j < kx; j++) begin
                    u  = (n - j >= 0 && n - j < n_bits) ? int'(bq[n - j]) : 0;
                    p1 = p1 ^ (((g0 >> (kx - 1 - j)) & 1) & u);
                    p0 = p0 ^ (((g1 >> (kx - 1 - j)) & 1) & u);
                end
                ph = n % per;
                mk = (ph == 0) ? 3 : (ph == 1) ? 2 : 1;
                ex.push_back(4'((((p1 * 2 + p0) & mk) * 4) + mk));
            end
        end
        nsym = ex.size();

        bi = 0; ri = 0; cyc = 0; stall = 0; acc = 0; stalled = 0; snap = '0;
        while (ri < nsym) begin
            if (cyc >= 400) begin
                chk({tag, " timeout symbols"}, 32'(ri), 32'(nsym));
                break;
            end
            @(negedge CLK);
            cyc++;
            if (stall_at >= 0 && ri == stall_at && stall < 4) begin
                rdy = 1'b0;
                stall++;
            end else begin
                rdy = rnd ? 1'($urandom_range(0, 3) != 0) : 1'b1;
            end
            if (!(iv && !acc)) begin
                if (bi < n_bits && (!rnd || $urandom_range(0, 2) != 0)) begin
                    iv      = 1'b1;
                    in_bit  = bq[bi];
                    in_last = (bi == n_bits - 1);
                    mode    = (bi == 0) ? mf : mr;
                end else begin
                    iv      = 1'b0;
                    in_bit  = 1'($urandom);
                    in_last = 1'($urandom);
                    mode    = 2'($urandom);
                end
            end
            #1;
            if (stalled) chk($sformatf("%s hold sym%0d", tag, ri), 32'({m_par, m_msk, m_ol, m_ov}), 32'(snap));
            if (m_ov && !rdy) chk($sformatf("%s in_ready stall sym%0d", tag, ri), 32'(m_ir), 32'd0);
            acc = iv && m_ir;
            if (acc) bi++;
            if (m_ov && rdy) begin
                chk($sformatf("%s par/mask sym%0d", tag, ri), 32'({m_par, m_msk}), 32'(ex[ri]));
                chk($sformatf("%s last sym%0d", tag, ri), 32'(m_ol), 32'(ri == nsym - 1));
                ri++;
                if (ri == rst_at) begin
                    RST = 1'b1;
                    iv  = 1'b0;
                    @(negedge CLK);
                    RST = 1'b0;
                    rdy = 1'b1;
                    #1;
                    chk({tag, " post-reset out_valid"}, 32'(m_ov), 32'd0);
                    chk({tag, " post-reset in_ready"}, 32'(m_ir), 32'd1);
                    return;
                end
            end
            stalled = m_ov && !rdy;
            snap    = {m_par, m_msk, m_ol, m_ov};
        end
        iv  = 1'b0;
        rdy = 1'b1;
        @(negedge CLK);
        #1;
        chk({tag, " idle out_valid"}, 32'(m_ov), 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge CLK);
        #1;
        chk("reset out_valid", 32'(ov3), 32'd0);
        chk("reset out_par", 32'(par3), 32'd0);
        chk("reset out_mask", 32'(msk3), 32'd0);
        chk("reset out_last", 32'(ol3), 32'd0);
        chk("reset out_valid k7", 32'(ov7), 32'd0);
        RST = 1'b0;
        @(negedge CLK);
        #1;
        chk("reset in_ready", 32'(ir3), 32'd1);
        chk("reset in_ready k7", 32'(ir7), 32'd1);

        load_bits(32'b10110, 5);
        load_exp(32'hFB377F3, 7);
        run_frame(1'b0, 2'd0, 2'd0, -1, -1, 1'b0, "t1");

        load_bits(32'b111, 3);
        load_exp(32'hF217A, 5);
        run_frame(1'b0, 2'd2, 2'd2, -1, -1, 1'b0, "t2");

        load_bits(32'b10110, 5);
        load_exp(32'hFB377F3, 7);
        run_frame(1'b0, 2'd0, 2'd0, 2, -1, 1'b0, "t3");

        load_bits(32'b10110, 5);
        load_exp(32'hFB377F3, 7);
        run_frame(1'b0, 2'd0, 2'd0, -1, 6, 1'b0, "t4rst");
        run_frame(1'b0, 2'd0, 2'd0, -1, -1, 1'b0, "t4rerun");

        load_bits(32'b10110, 5);
        xq.delete();
        run_frame(1'b0, 2'd1, 2'd2, -1, -1, 1'b0, "t5a");
        run_frame(1'b0, 2'd3, 2'd0, -1, -1, 1'b0, "t5b");

        load_bits(32'b1, 1);
        load_exp(32'hFBFF37F, 7);
        run_frame(1'b1, 2'd0, 2'd0, -1, -1, 1'b0, "t6");

        xq.delete();
        for (int f = 0; f < 24; f++) begin
            int n;
            n = $urandom_range(1, 12);
            load_bits($urandom, n);
            run_frame(f % 6 == 5, 2'($urandom), 2'($urandom), -1, -1, 1'b1, $sformatf("rand%0d", f));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
